// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, SERVE} arb_state_t;

  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_NUM_REQ = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    // ptr itself is visited last, so it has the lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Optional multi-beat grants are enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IW       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DW-1:0]         fifo_data_in,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..15");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [IW-1:0]      pick_base, pick_idx;
  logic               pick_found;

  logic holder_valid, accept, last_beat, rearb;

  assign holder_valid = req_valid[grant_id_q];
  // rst gates the write so a beat presented during reset is never taken.
  assign accept = (state_q == SERVE) && holder_valid && !fifo_full && !rst;

  // In SERVE the holder is masked out and becomes lowest priority.
  always_comb begin
    pick_req  = req_valid;
    pick_base = ptr_q;
    if (state_q == SERVE) begin
      pick_req[grant_id_q] = 1'b0;
      pick_base            = grant_id_q;
    end
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (pick_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] beat_cnt_q, beat_cnt_d;

  assign last_beat = (beat_cnt_q == 4'(MAX_BURST - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE || rearb) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      ptr_q      <= IW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    rearb      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = SERVE;
          grant_id_d = pick_idx;
        end
      end
      SERVE: begin
        // A full fifo freezes the grant, even if the holder drops valid.
        if (!fifo_full) begin
          if (!holder_valid) begin
            rearb = 1'b1;
          end else if (accept && last_beat) begin
            rearb = 1'b1;
            ptr_d = grant_id_q;
          end
        end
        if (rearb) begin
          if (pick_found) begin
            grant_id_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en   = accept;
    fifo_data_in = '0;
    req_ready    = '0;
    grant_valid  = (state_q == SERVE);
    grant_id     = grant_id_q;
    if (state_q == SERVE) begin
      fifo_data_in = req_data[grant_id_q*DW +: DW];
    end
    if (accept) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DW=8).
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 8;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_data_in;
  logic                  grant_valid;
  logic [1:0]            grant_id;

  int checks;
  int errors;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DW        (DW),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset req_ready: got %b want %b", req_ready, 4'b0000);
      end
      checks++;
      if (fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL reset fifo_wr_en: got %b want 0", fifo_wr_en);
      end
      checks++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset grant_valid: got %b want 0", grant_valid);
      end
      checks++;
      if (grant_id !== 2'd0) begin
        errors++;
        $display("FAIL reset grant_id: got %0d want 0", grant_id);
      end
    end
    step();
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    apply_reset();
    req_data[2*DW +: DW] = 8'hA5;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if ({grant_valid, fifo_wr_en} !== 2'b00) begin
      errors++;
      $display("FAIL single idle {gv,wr}: got %b want 00", {grant_valid, fifo_wr_en});
    end
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL single grant: got id=%0d gv=%b want id=2 gv=1", grant_id, grant_valid);
    end
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data_in !== 8'hA5) begin
      errors++;
      $display("FAIL single write: got wr=%b data=%h want wr=1 data=a5", fifo_wr_en, fifo_data_in);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single req_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single back to idle: got gv=%b want 0", grant_valid);
    end
`ifndef FIFO_ARB_BURST_EN
    // ptr now sits at 2, so req 3 is searched before req 0.
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd3) begin
      errors++;
      $display("FAIL single ptr advance: got id=%0d want 3", grant_id);
    end
`endif
    step();
    req_valid = '0;
  endtask

`ifndef FIFO_ARB_BURST_EN
  task automatic test_fairness();
    logic [DW-1:0]      exp_data;
    logic [NUM_REQ-1:0] exp_ready;
    logic [1:0]         exp_id;
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    step();
    for (int k = 0; k < 8; k++) begin
      exp_id    = 2'(k % 4);
      exp_data  = 8'(8'h11 * (k % 4 + 1));
      exp_ready = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== exp_id) begin
        errors++;
        $display("FAIL fairness beat %0d: got wr=%b id=%0d want wr=1 id=%0d",
                 k, fifo_wr_en, grant_id, exp_id);
      end
      checks++;
      if (fifo_data_in !== exp_data || req_ready !== exp_ready) begin
        errors++;
        $display("FAIL fairness data %0d: got data=%h rdy=%b want data=%h rdy=%b",
                 k, fifo_data_in, req_ready, exp_data, exp_ready);
      end
      step();
    end
    req_valid = '0;
  endtask
`else
  task automatic test_burst();
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b0011;
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'(k / 4)) begin
        errors++;
        $display("FAIL burst beat %0d: got wr=%b id=%0d want wr=1 id=%0d",
                 k, fifo_wr_en, grant_id, k / 4);
      end
      step();
    end
    apply_reset();
    req_valid = 4'b0011;
    step();
    repeat (2) step();
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL burst drop: got wr=%b id=%0d want wr=0 id=0", fifo_wr_en, grant_id);
    end
    step();
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL burst regrant: got wr=%b id=%0d want wr=1 id=1", fifo_wr_en, grant_id);
    end
    step();
    req_valid = '0;
  endtask
`endif

  task automatic test_backpressure();
    apply_reset();
    req_data[1*DW +: DW] = 8'h3C;
    req_valid = 4'b0010;
    fifo_full = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure stall %0d: got wr=%b rdy=%b want wr=0 rdy=0000",
                 k, fifo_wr_en, req_ready);
      end
      checks++;
      if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure hold %0d: got id=%0d gv=%b want id=1 gv=1",
                 k, grant_id, grant_valid);
      end
      step();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_data_in !== 8'h3C || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL backpressure resume: got wr=%b data=%h rdy=%b want wr=1 data=3c rdy=0010",
               fifo_wr_en, fifo_data_in, req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure end: got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_violation();
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b0001;
    fifo_full = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL violation grant: got id=%0d gv=%b want id=0 gv=1", grant_id, grant_valid);
    end
    step();
    fifo_full = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL violation no write: got wr=%b want 0", fifo_wr_en);
    end
    step();
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL violation idle: got gv=%b want 0", grant_valid);
    end
    // ptr must still be 3 after a dropped grant, so req 0 beats req 3.
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL violation ptr held: got id=%0d want 0", grant_id);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1000;
    fifo_full = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd3 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid grant: got id=%0d gv=%b want id=3 gv=1", grant_id, grant_valid);
    end
    step();
    rst       = 1'b1;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid gated: got wr=%b rdy=%b want wr=0 rdy=0000", fifo_wr_en, req_ready);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid cleared: got gv=%b id=%0d want gv=0 id=0", grant_valid, grant_id);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || fifo_data_in !== 8'h11) begin
      errors++;
      $display("FAIL reset_mid req0 first: got id=%0d wr=%b data=%h want id=0 wr=1 data=11",
               grant_id, fifo_wr_en, fifo_data_in);
    end
    step();
    req_valid = '0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    fifo_full = 1'b0;
    test_reset();
    test_single();
`ifndef FIFO_ARB_BURST_EN
    test_fairness();
`else
    test_burst();
`endif
    test_backpressure();
    test_violation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
